// File: rtl/b_lut_inv.sv
// b_lut_inv: inverse-substitution engine for the 4-bit LUT datapath.
// Builds the inverse of a 16-entry nibble LUT one entry per cycle, flags
// non-permutations, applies the inverse to the eight nibbles of crs1, and
// keeps the last fully built inverse so repeat decodes skip the build.
module b_lut_inv #(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] crs1,
    input  logic [31:0] crs2,
    input  logic [31:0] crs3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        not_perm
);

    localparam int unsigned NIB_W = 4;
    localparam int unsigned N_ENT = 16;
    localparam int unsigned N_NIB = 8;
    localparam int unsigned XLEN  = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUILD = 2'd1,
        S_APPLY = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                         state_q;
    logic [NIB_W-1:0]               idx_q;
    logic [N_ENT-1:0][NIB_W-1:0]    lut_q;
    logic [XLEN-1:0]                crs1_q;
    logic [N_ENT-1:0]               seen_q;
    logic [N_ENT-1:0][NIB_W-1:0]    inv_q;
    logic                           dup_q;
    logic                           hit_q;
    logic [N_ENT-1:0][NIB_W-1:0]    cache_lut_q;
    logic                           cache_dup_q;
    logic                           cache_vld_q;
    logic                           in_ready_q;
    logic                           out_valid_q;
    logic [XLEN-1:0]                result_q;
    logic                           not_perm_q;

    logic                           cache_hit_c;
    logic [NIB_W-1:0]               lut_v_c;
    logic [XLEN-1:0]                result_d;

    // Cache hit: same LUT as the last completed build.
    assign cache_hit_c = CACHE_EN && cache_vld_q && (cache_lut_q == {crs3, crs2});

    // LUT entry being inverted this BUILD cycle.
    assign lut_v_c = lut_q[idx_q];

    // Parallel inverse lookup of all latched crs1 nibbles.
    always_comb begin
        result_d = '0;
        for (int k = 0; k < N_NIB; k++) begin
            result_d[k*NIB_W +: NIB_W] = inv_q[crs1_q[k*NIB_W +: NIB_W]];
        end
    end

    // Control FSM, inverse table build, cache and registered outputs.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            lut_q       <= '0;
            crs1_q      <= '0;
            seen_q      <= '0;
            inv_q       <= '0;
            dup_q       <= 1'b0;
            hit_q       <= 1'b0;
            cache_lut_q <= '0;
            cache_dup_q <= 1'b0;
            cache_vld_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            not_perm_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        crs1_q     <= crs1;
                        lut_q      <= {crs3, crs2};
                        if (cache_hit_c) begin
                            hit_q   <= 1'b1;
                            state_q <= S_APPLY;
                        end else begin
                            hit_q   <= 1'b0;
                            seen_q  <= '0;
                            inv_q   <= '0;
                            dup_q   <= 1'b0;
                            idx_q   <= '0;
                            state_q <= S_BUILD;
                        end
                    end
                end
                S_BUILD: begin
                    // Later duplicates overwrite earlier ones.
                    inv_q[lut_v_c]  <= idx_q;
                    seen_q[lut_v_c] <= 1'b1;
                    if (seen_q[lut_v_c]) begin
                        dup_q <= 1'b1;
                    end
                    if (idx_q == 4'(N_ENT - 1)) begin
                        cache_lut_q <= lut_q;
                        cache_dup_q <= dup_q | seen_q[lut_v_c];
                        cache_vld_q <= 1'b1;
                        state_q     <= S_APPLY;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                S_APPLY: begin
                    result_q   <= result_d;
                    not_perm_q <= hit_q ? cache_dup_q : dup_q;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    // First DONE cycle raises out_valid; then wait for consumer.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign not_perm  = not_perm_q;

endmodule

// File: tb/tb_b_lut_inv.sv
// Scoreboard bench for b_lut_inv: driver pushes expected responses from a
// behavioural inverse model; a negedge monitor pops and compares them.
module tb_b_lut_inv;

    logic        g_clk;
    logic        g_resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] crs1;
    logic [31:0] crs2;
    logic [31:0] crs3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        not_perm;

    b_lut_inv #(.CACHE_EN(1'b1)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .crs1      (crs1),
        .crs2      (crs2),
        .crs3      (crs3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .not_perm  (not_perm)
    );

    typedef struct {
        logic [31:0] res;
        logic        np;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sc_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc = 0;
    int          bp_mode = 0;
    logic        m_cache_vld = 1'b0;
    logic [63:0] m_cache_lut = '0;
    logic        prev_ov = 1'b0;
    logic [31:0] hold_res = '0;
    logic        hold_np = 1'b0;

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    always @(posedge g_clk) cyc <= cyc + 1;

    // Random consumer backpressure unless a directed test owns out_ready.
    always @(negedge g_clk) begin
        if (bp_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: inverse by direct table definition, duplicates by counting.
    function automatic void model(input logic [63:0] lut, input logic [31:0] c1,
                                  output logic [31:0] res, output logic np);
        logic [3:0] inv [16];
        int         cnt [16];
        logic [3:0] v;
        for (int i = 0; i < 16; i++) begin
            inv[i] = 4'h0;
            cnt[i] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            v = lut[4*i +: 4];
            inv[v] = 4'(i);
            cnt[v] = cnt[v] + 1;
        end
        np = 1'b0;
        for (int i = 0; i < 16; i++) if (cnt[i] > 1) np = 1'b1;
        res = '0;
        for (int k = 0; k < 8; k++) res[4*k +: 4] = inv[c1[4*k +: 4]];
    endfunction

    task automatic drive_req(input logic [31:0] c1, input logic [31:0] c2, input logic [31:0] c3);
        crs1     = c1;
        crs2     = c2;
        crs3     = c3;
        in_valid = 1'b1;
    endtask

    // Called at a negedge with a request driven: wait for acceptance, push expectation.
    task automatic wait_accept();
        exp_t        e;
        logic [63:0] lut;
        bit          ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge g_clk);
        end
        if (!ok) begin
            $display("FAIL accept_timeout: in_ready never rose (cycle %0d)", cyc);
            errors++;
            checks++;
            in_valid = 1'b0;
            return;
        end
        lut   = {crs3, crs2};
        model(lut, crs1, e.res, e.np);
        e.acc = cyc + 1;
        if (m_cache_vld && lut == m_cache_lut) begin
            e.lat = 2;
        end else begin
            e.lat       = 18;
            m_cache_vld = 1'b1;
            m_cache_lut = lut;
        end
        sc_q.push_back(e);
        last_acc = e.acc;
        @(posedge g_clk);
        #1;
        in_valid = 1'b0;
        crs1 = $urandom;
        crs2 = $urandom;
        crs3 = $urandom;
    endtask

    task automatic send(input logic [31:0] c1, input logic [31:0] c2, input logic [31:0] c3);
        @(negedge g_clk);
        drive_req(c1, c2, c3);
        wait_accept();
    endtask

    task automatic wait_out_valid();
        for (int n = 0; n < 100; n++) begin
            if (out_valid) return;
            @(negedge g_clk);
        end
        $display("FAIL out_valid_timeout: out_valid stayed %b (cycle %0d)", out_valid, cyc);
        errors++;
        checks++;
    endtask

    // Monitor: compare each new result, then check it stays stable while held.
    always @(negedge g_clk) begin
        exp_t e;
        if (!g_resetn) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                if (!prev_ov) begin
                    if (sc_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_output: result %h with empty scoreboard", result);
                    end else begin
                        e = sc_q.pop_front();
                        chk("result", result, e.res);
                        chk("not_perm", 32'(not_perm), 32'(e.np));
                        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    end
                    hold_res = result;
                    hold_np  = not_perm;
                end else begin
                    chk("hold_result", result, hold_res);
                    chk("hold_not_perm", 32'(not_perm), 32'(hold_np));
                end
                chk("in_ready_in_done", 32'(in_ready), 32'd0);
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        logic [3:0]  p [16];
        logic [3:0]  t;
        logic [63:0] lut;
        logic [63:0] last_lut;
        int          j;
        int          cons;

        g_resetn  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        crs1 = '0;
        crs2 = '0;
        crs3 = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_not_perm", 32'(not_perm), 32'd0);
        @(negedge g_clk);
        g_resetn = 1'b1;

        // Directed cases: identity (cold), reverse, hit, one-nibble change, all-zero LUT.
        send(32'h12345678, 32'h76543210, 32'hFEDCBA98);
        send(32'h0000000F, 32'h89ABCDEF, 32'h01234567);
        send(32'hF0F0F0F0, 32'h89ABCDEF, 32'h01234567);
        send(32'h13579BDF, 32'h89ABCDEE, 32'h01234567);
        send(32'h00000001, 32'h00000000, 32'h00000000);

        // Backpressure: hold result 5 cycles with a second request pending.
        wait (sc_q.size() == 0);
        @(negedge g_clk);
        bp_mode   = 1;
        out_ready = 1'b0;
        send(32'h89ABCDEF, 32'h76543210, 32'hFEDCBA98);
        wait_out_valid();
        @(negedge g_clk);
        drive_req(32'h0000FFFF, 32'h76543210, 32'hFEDCBA98);
        repeat (5) begin
            @(negedge g_clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        cons = cyc + 1;
        @(negedge g_clk);
        wait_accept();
        chk("bp_accept_cycle", 32'(last_acc), 32'(cons + 1));
        wait_out_valid();
        @(negedge g_clk);
        bp_mode = 0;

        // Randomized traffic: permutations, arbitrary LUTs, and repeats for hits.
        last_lut = {32'hFEDCBA98, 32'h76543210};
        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 2))
                0: begin
                    for (int i = 0; i < 16; i++) p[i] = 4'(i);
                    for (int i = 15; i > 0; i--) begin
                        j    = $urandom_range(0, i);
                        t    = p[i];
                        p[i] = p[j];
                        p[j] = t;
                    end
                    for (int i = 0; i < 16; i++) lut[4*i +: 4] = p[i];
                end
                1: lut = {$urandom, $urandom};
                default: lut = last_lut;
            endcase
            last_lut = lut;
            send($urandom, lut[31:0], lut[63:32]);
        end

        // Reset during BUILD at idx 7; the same LUT must then rebuild.
        wait (sc_q.size() == 0);
        send(32'h0F1E2D3C, 32'h87654321, 32'h0FEDCBA9);
        repeat (7) @(posedge g_clk);
        #2;
        g_resetn = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_not_perm", 32'(not_perm), 32'd0);
        sc_q.delete();
        m_cache_vld = 1'b0;
        @(negedge g_clk);
        g_resetn = 1'b1;
        send(32'h0F1E2D3C, 32'h87654321, 32'h0FEDCBA9);

        // Drain the scoreboard with a bounded wait.
        for (int n = 0; n < 2000 && sc_q.size() != 0; n++) @(negedge g_clk);
        chk("scoreboard_drained", 32'(sc_q.size()), 32'd0);
        repeat (3) @(negedge g_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
